sram_access_arbiter: RTL
========================

Name: sram_access_arbiter

Overview:
- Sequences and shares the single asynchronous SRAM port between two requesters: the CPU memory path (reads/writes) and the video fetch engine (reads only).
- Sits between the memory control unit's SRAM side and the chip pins.
- Produces glitch-free registered chip strobes with parameterised access timing.
- Returns read data with a one-cycle acknowledge per requester.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_CYCLES, 2, cycles Mem_OE is held per read (min 1).
- WR_CYCLES, 2, cycles per write; Mem_WE is high for the first WR_CYCLES-1 of them (min 2).
- VID_STREAK_MAX, 4, consecutive video grants allowed while CPU waits (min 1).

Ports:
- Clk  in  1  system clock.
- Reset_N  in  1  reset; asynchronous, active-low.
- Cpu_Req  in  1  CPU access request; held until Cpu_Ack.
- Cpu_WE  in  1  1 = write, 0 = read; stable while Cpu_Req high.
- Cpu_Addr  in  ADDR_W  CPU address.
- Cpu_WData  in  DATA_W  CPU write data.
- Cpu_RData  out  DATA_W  CPU read data; valid from Cpu_Ack, held until the next CPU read completes.
- Cpu_Ack  out  1  one-cycle completion pulse.
- Vid_Req  in  1  video read request; held until Vid_Ack.
- Vid_Addr  in  ADDR_W  video read address.
- Vid_RData  out  DATA_W  video read data; same validity rule as Cpu_RData.
- Vid_Ack  out  1  one-cycle completion pulse.
- SRAM_Addr  out  ADDR_W  chip address.
- SRAM_DQ_Out  out  DATA_W  write data to the tri-state.
- SRAM_DQ_OE  out  1  tri-state drive enable.
- SRAM_DQ_In  in  DATA_W  data from the tri-state.
- Mem_CE, Mem_OE, Mem_WE  out  1 each  chip strobes, active-high at this boundary.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Reset_N low, asynchronous):
  - state = IDLE; all outputs 0; RData registers 0; streak counter 0.
  - Any in-flight access is aborted immediately: strobes and DQ_OE drop asynchronously, and no Ack is issued for it.
- All SRAM-side outputs, Acks and RData are registers. No combinational path from inputs to outputs.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: requests are sampled at each edge.
  - Video only -> READ with Vid_Addr.
  - CPU only -> READ or WRITE per Cpu_WE.
  - Both -> video wins, unless streak == VID_STREAK_MAX, in which case the CPU wins.
  - Neither -> stay in IDLE.
  - Grant owner, address and write data are latched on the transition.
- READ:
  - Mem_CE = Mem_OE = 1 for RD_CYCLES cycles; SRAM_Addr stable.
  - SRAM_DQ_In is captured into the owner's RData at the edge ending the last READ cycle.
  - Then -> DONE.
- WRITE:
  - Mem_CE = 1 and SRAM_DQ_OE = 1 for all WR_CYCLES cycles.
  - Mem_WE = 1 for cycles 1..WR_CYCLES-1 and 0 in the final cycle, giving address/data hold after the WE rising edge.
  - Then -> DONE.
- DONE:
  - All strobes 0, DQ_OE 0 (bus turnaround); owner's Ack = 1 for exactly this cycle.
  - Requests are ignored in DONE; next state is always IDLE.
  - A Req still high in the following IDLE cycle is a new request, so requesters must drop Req the cycle after Ack unless they intend a back-to-back access.
- Latency, from the cycle Req is first seen in IDLE:
  - Ack arrives RD_CYCLES+1 cycles later (read) or WR_CYCLES+1 cycles later (write).
  - Minimum request-to-request spacing: RD_CYCLES+2 or WR_CYCLES+2 cycles.
- Streak counter (updated at each grant):
  - Video grant while Cpu_Req high -> increment, saturating at VID_STREAK_MAX.
  - Video grant while Cpu_Req low -> clear.
  - Any CPU grant -> clear.
- Changes to Cpu_Addr/Cpu_WData/Vid_Addr after a grant do not affect the access in flight.
- Ack never pulses for a requester that was not granted. Cpu_Ack and Vid_Ack are never high together.

Test Plan:
- Reset, then CPU write 0x00123 <- 0xBEEF (RD=2, WR=2) -> Mem_WE high exactly 1 cycle, DQ_OE high 2 cycles, Cpu_Ack 3 cycles after Req; CPU read 0x00123 -> Cpu_RData = 0xBEEF with Cpu_Ack 3 cycles after Req.
- Cpu_Req and Vid_Req rise in the same IDLE cycle -> video granted first (Vid_Ack), CPU served next, Cpu_Ack 4 cycles after Vid_Ack.
- Vid_Req held continuously with Cpu_Req high, VID_STREAK_MAX=4 -> exactly 4 Vid_Acks, then one Cpu_Ack, then video resumes; the streak restarts from 0.
- Reset_N pulsed low mid-READ -> Mem_OE/Mem_CE go 0 without a clock edge, no Ack ever issued, state IDLE after release, RData = 0x0000.
- RD_CYCLES=3, WR_CYCLES=4 build -> Mem_OE high 3 cycles, Mem_WE high 3 cycles then 1 hold cycle; Busy low in IDLE only.
- Cpu_Addr changed during a WRITE -> SRAM_Addr stays at the latched value until DONE.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Two-requester (CPU read/write, video read-only) sequencer for a single asynchronous SRAM port.
// All chip strobes, acks and read data are registered; reset aborts any access in flight.
`timescale 1ns/1ps
module sram_access_arbiter #(
  parameter int unsigned ADDR_W         = 20,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned RD_CYCLES      = 2,
  parameter int unsigned WR_CYCLES      = 2,
  parameter int unsigned VID_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              mem_ce,
  output logic              mem_oe,
  output logic              mem_we,
  output logic              busy
);

  localparam int unsigned CntMax = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned StkW   = $clog2(VID_STREAK_MAX + 1);
  localparam logic [CntW-1:0] RdLast = CntW'(RD_CYCLES - 1);
  localparam logic [CntW-1:0] WrLast = CntW'(WR_CYCLES - 1);
  localparam logic [StkW-1:0] StkMax = StkW'(VID_STREAK_MAX);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [StkW-1:0]   streak_q, streak_d;
  logic              vid_own_q, vid_own_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic              ce_q, ce_d, oe_q, oe_d, we_q, we_d, dqoe_q, dqoe_d;
  logic              cpu_ack_q, cpu_ack_d, vid_ack_q, vid_ack_d, busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    vid_own_d   = vid_own_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    unique case (state_q)
      StIdle: begin
        // Video has priority unless the CPU has already waited out a full streak.
        if (vid_req && !(cpu_req && streak_q == StkMax)) begin
          state_d   = StRead;
          vid_own_d = 1'b1;
          addr_d    = vid_addr;
          cnt_d     = '0;
          if (!cpu_req)                streak_d = '0;
          else if (streak_q != StkMax) streak_d = streak_q + StkW'(1);
        end else if (cpu_req) begin
          state_d   = cpu_we ? StWrite : StRead;
          vid_own_d = 1'b0;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          cnt_d     = '0;
          streak_d  = '0;
        end
      end
      StRead: begin
        if (cnt_q == RdLast) begin
          state_d = StDone;
          if (vid_own_q) vid_rdata_d = sram_dq_in;
          else           cpu_rdata_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWrite: begin
        if (cnt_q == WrLast) state_d = StDone;
        else                 cnt_d   = cnt_q + CntW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Strobes are decoded from the next state so they come straight out of flops.
    ce_d      = (state_d == StRead) || (state_d == StWrite);
    oe_d      = (state_d == StRead);
    dqoe_d    = (state_d == StWrite);
    we_d      = (state_d == StWrite) && (cnt_d != WrLast);
    cpu_ack_d = (state_d == StDone) && !vid_own_d;
    vid_ack_d = (state_d == StDone) && vid_own_d;
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      streak_q    <= '0;
      vid_own_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      ce_q        <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      dqoe_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      vid_own_q   <= vid_own_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      dqoe_q      <= dqoe_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_rdata   = cpu_rdata_q;
  assign vid_rdata   = vid_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_ack     = vid_ack_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign sram_dq_oe  = dqoe_q;
  assign mem_ce      = ce_q;
  assign mem_oe      = oe_q;
  assign mem_we      = we_q;
  assign busy        = busy_q;

endmodule
